// File: rtl/vend_output_ctrl_if.sv
// Bundles the coin-FSM state input, the error clear and every drive/display output of vend_output_ctrl.
// Valid/ready: there is no handshake; state is sampled on every sys_clk edge and the outputs are registered levels.
interface vend_output_ctrl_if;
    logic [6:0] state;
    logic       err_clr;
    logic       po_cola;
    logic       po_money;
    logic [3:0] led;
    logic [7:0] cola_cnt;
    logic [7:0] change_cnt;
    logic       err;
    logic       dbg_dispense;

    modport master (
        output state, err_clr,
        input  po_cola, po_money, led, cola_cnt, change_cnt, err, dbg_dispense
    );

    modport slave (
        input  state, err_clr,
        output po_cola, po_money, led, cola_cnt, change_cnt, err, dbg_dispense
    );
endinterface

// File: rtl/vend_output_ctrl.sv
// Vend output stage: timed dispense/change pulses, credit LED display with dispense blink,
// saturating sales counters and a sticky illegal-state flag.
module vend_output_ctrl #(
    parameter int HOLD_CYC  = 25_000_000,
    parameter int BLINK_CYC = 5_000_000,
    parameter int CNT_W     = 25
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    vend_output_ctrl_if.slave   bus
);
    typedef enum logic {S_IDLE, S_DISPENSE} fsm_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

    fsm_t             fsm_q, fsm_d;
    logic             po_cola_q, po_cola_d;
    logic             po_money_q, po_money_d;
    logic [3:0]       led_q, led_d;
    logic [7:0]       cola_cnt_q, cola_cnt_d;
    logic [7:0]       change_cnt_q, change_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic [6:0]       state_prev_q, state_prev_d;

    logic       is_vend;
    logic       is_legal;
    logic       vend_ev;
    logic       vend_change;
    logic [3:0] credit_led;

    // Decode the incoming code once: display pattern, legality and vend-code detection.
    always_comb begin
        credit_led = 4'b0000;
        is_legal   = 1'b1;
        case (bus.state)
            7'b0000001: credit_led = 4'b0000;
            7'b0000010: credit_led = 4'b0001;
            7'b0000100: credit_led = 4'b0011;
            7'b0001000: credit_led = 4'b0111;
            7'b0010000: credit_led = 4'b1111;
            7'b0100001: credit_led = 4'b0000;
            7'b1000001: credit_led = 4'b0000;
            default:    is_legal   = 1'b0;
        endcase
    end

    assign is_vend     = (bus.state == 7'b0100001) || (bus.state == 7'b1000001);
    assign vend_ev     = (bus.state != state_prev_q) && is_vend;
    assign vend_change = (bus.state[6:5] == 2'b10);

    always_comb begin
        fsm_d        = fsm_q;
        po_cola_d    = po_cola_q;
        po_money_d   = po_money_q;
        led_d        = credit_led;
        hold_cnt_d   = hold_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_ph_d   = blink_ph_q;
        state_prev_d = bus.state;

        // A vend event always (re)starts the pulse, even on the last hold cycle.
        if (vend_ev) begin
            fsm_d       = S_DISPENSE;
            po_cola_d   = 1'b1;
            po_money_d  = vend_change;
            hold_cnt_d  = '0;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
            led_d       = 4'b1111;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    led_d = credit_led;
                end
                S_DISPENSE: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        fsm_d      = S_IDLE;
                        po_cola_d  = 1'b0;
                        po_money_d = 1'b0;
                        led_d      = credit_led;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d = '0;
                            blink_ph_d  = ~blink_ph_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                        led_d = {4{blink_ph_d}};
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    // Counters stick at 255; set wins over clear for err.
    always_comb begin
        cola_cnt_d   = cola_cnt_q;
        change_cnt_d = change_cnt_q;
        if (vend_ev && (cola_cnt_q != 8'hFF)) cola_cnt_d = cola_cnt_q + 8'd1;
        if (vend_ev && vend_change && (change_cnt_q != 8'hFF)) change_cnt_d = change_cnt_q + 8'd1;
        err_d = !is_legal || (err_q && !bus.err_clr);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fsm_q        <= S_IDLE;
            po_cola_q    <= 1'b0;
            po_money_q   <= 1'b0;
            led_q        <= 4'b0000;
            cola_cnt_q   <= 8'd0;
            change_cnt_q <= 8'd0;
            err_q        <= 1'b0;
            hold_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b1;
            state_prev_q <= 7'b0000001;
        end else begin
            fsm_q        <= fsm_d;
            po_cola_q    <= po_cola_d;
            po_money_q   <= po_money_d;
            led_q        <= led_d;
            cola_cnt_q   <= cola_cnt_d;
            change_cnt_q <= change_cnt_d;
            err_q        <= err_d;
            hold_cnt_q   <= hold_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            state_prev_q <= state_prev_d;
        end
    end

    assign bus.po_cola      = po_cola_q;
    assign bus.po_money     = po_money_q;
    assign bus.led          = led_q;
    assign bus.cola_cnt     = cola_cnt_q;
    assign bus.change_cnt   = change_cnt_q;
    assign bus.err          = err_q;
    assign bus.dbg_dispense = (fsm_q == S_DISPENSE);
endmodule

// File: tb/tb_vend_output_ctrl.sv
// Self-checking bench for vend_output_ctrl with a pulse/credit reference model.
module tb_vend_output_ctrl;
    localparam int HOLD  = 10;
    localparam int BLINK = 3;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    vend_output_ctrl_if ifc();

    vend_output_ctrl #(.HOLD_CYC(HOLD), .BLINK_CYC(BLINK), .CNT_W(25)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (ifc)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining pulse cycles, elapsed dispense time, sales totals.
    logic [6:0] m_prev;
    int         m_rem;
    int         m_t;
    bit         m_money;
    int         m_cola;
    int         m_change;
    bit         m_err;
    logic [3:0] m_led;

    function automatic bit is_vend(input logic [6:0] s);
        return (s == 7'b0100001) || (s == 7'b1000001);
    endfunction

    function automatic bit is_legal(input logic [6:0] s);
        return is_vend(s) || ((s[6:5] == 2'b00) && ($countones(s[4:0]) == 1));
    endfunction

    // Number of lit LEDs equals the credit in half-units.
    function automatic logic [3:0] credit_led_ref(input logic [6:0] s);
        int n;
        int v;
        n = 0;
        if (!is_legal(s) || is_vend(s)) return 4'b0000;
        for (int i = 0; i < 5; i++) if (s[i]) n = i;
        v = (1 << n) - 1;
        return v[3:0];
    endfunction

    function automatic logic [23:0] model_vec();
        return {m_rem > 0, (m_rem > 0) && m_money, m_led, m_cola[7:0], m_change[7:0], m_err, m_rem > 0};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {ifc.po_cola, ifc.po_money, ifc.led, ifc.cola_cnt, ifc.change_cnt, ifc.err, ifc.dbg_dispense};
    endfunction

    task automatic model_reset();
        m_prev = 7'b0000001; m_rem = 0; m_t = 0; m_money = 0;
        m_cola = 0; m_change = 0; m_err = 0; m_led = 4'b0000;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic clr);
        if ((s !== m_prev) && is_vend(s)) begin
            m_rem   = HOLD;
            m_t     = 0;
            m_money = (s[6:5] == 2'b10);
            if (m_cola < 255) m_cola++;
            if (m_money && m_change < 255) m_change++;
        end else if (m_rem > 0) begin
            m_rem--;
            m_t++;
        end
        m_led  = (m_rem > 0) ? ((((m_t / BLINK) % 2) == 0) ? 4'hF : 4'h0) : credit_led_ref(s);
        m_err  = !is_legal(s) || (m_err && !clr);
        m_prev = s;
    endtask

    task automatic drive(input logic [6:0] s, input logic clr);
        @(negedge sys_clk);
        ifc.state   = s;
        ifc.err_clr = clr;
        @(posedge sys_clk);
        model_edge(s, clr);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_n   = 1'b0;
        ifc.state   = 7'b0000001;
        ifc.err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst_n   = 1'b0;
        ifc.state   = 7'b0000001;
        ifc.err_clr = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 24'h0) begin
            failures++;
            $display("FAIL reset_outputs dut=%h exp=%h", dut_vec(), 24'h0);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drive(7'b0000001, 1'b0);
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_idle dut=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_credit_display();
        logic [6:0] codes [5] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000};
        logic [3:0] leds  [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(codes[i], 1'b0);
            checks++;
            if (ifc.led !== leds[i] || ifc.po_cola !== 1'b0 || ifc.po_money !== 1'b0) begin
                failures++;
                $display("FAIL credit_led[%0d] led=%b po=%b%b exp led=%b po=00", i, ifc.led, ifc.po_cola, ifc.po_money, leds[i]);
            end
        end
    endtask

    task automatic test_vend_cola();
        logic [3:0] led_exp [11] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
        int highs;
        highs = 0;
        apply_reset();
        drive(7'b0001000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(7'b0100001, 1'b0);
            if (ifc.po_cola === 1'b1) highs++;
            if (i < 11) begin
                checks++;
                if (ifc.led !== led_exp[i] || ifc.po_money !== 1'b0) begin
                    failures++;
                    $display("FAIL cola_led[%0d] led=%b money=%b exp led=%b money=0", i, ifc.led, ifc.po_money, led_exp[i]);
                end
            end
        end
        checks++;
        if (highs !== HOLD || ifc.cola_cnt !== 8'd1 || ifc.change_cnt !== 8'd0) begin
            failures++;
            $display("FAIL cola_pulse width=%0d cola=%0d change=%0d exp width=%0d cola=1 change=0", highs, ifc.cola_cnt, ifc.change_cnt, HOLD);
        end
    endtask

    task automatic test_vend_change();
        int c_hi;
        int m_hi;
        c_hi = 0; m_hi = 0;
        apply_reset();
        drive(7'b0010000, 1'b0);
        for (int i = 0; i < 15; i++) begin
            drive(7'b1000001, 1'b0);
            if (ifc.po_cola === 1'b1) c_hi++;
            if (ifc.po_money === 1'b1) m_hi++;
        end
        checks++;
        if (c_hi !== HOLD || m_hi !== HOLD || ifc.cola_cnt !== 8'd1 || ifc.change_cnt !== 8'd1) begin
            failures++;
            $display("FAIL change_pulse cola_w=%0d money_w=%0d cola=%0d change=%0d exp %0d %0d 1 1", c_hi, m_hi, ifc.cola_cnt, ifc.change_cnt, HOLD, HOLD);
        end
    endtask

    task automatic test_back_to_back();
        int c_hi;
        int m_hi;
        int first_low;
        c_hi = 0; m_hi = 0; first_low = -1;
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            if (i < 9) drive(7'b0100001, 1'b0);
            else if (i == 9) drive(7'b0000010, 1'b0);
            else drive(7'b1000001, 1'b0);
            if (ifc.po_cola === 1'b1) c_hi++;
            else if (first_low < 0) first_low = i;
            if (ifc.po_money === 1'b1) m_hi++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL restart_cyc[%0d] dut=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        checks++;
        if (c_hi !== 2 * HOLD || first_low !== 2 * HOLD || m_hi !== HOLD || ifc.cola_cnt !== 8'd2) begin
            failures++;
            $display("FAIL restart_final cola_w=%0d first_low=%0d money_w=%0d cola=%0d exp %0d %0d %0d 2", c_hi, first_low, m_hi, ifc.cola_cnt, 2 * HOLD, 2 * HOLD, HOLD);
        end
    endtask

    task automatic test_illegal();
        logic [6:0] st  [4] = '{7'b0000011, 7'b1100001, 7'b0000011, 7'b0000001};
        logic       clr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       err_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(st[i], clr[i]);
            checks++;
            if (ifc.err !== err_exp[i] || ifc.led !== 4'b0000 || ifc.po_cola !== 1'b0 || ifc.cola_cnt !== 8'd0) begin
                failures++;
                $display("FAIL illegal[%0d] err=%b led=%b po=%b cola=%0d exp err=%b led=0000 po=0 cola=0", i, ifc.err, ifc.led, ifc.po_cola, ifc.cola_cnt, err_exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            drive(7'b1000001, 1'b0);
            drive(7'b0000001, 1'b0);
        end
        checks++;
        if (ifc.cola_cnt !== 8'd255 || ifc.change_cnt !== 8'd255) begin
            failures++;
            $display("FAIL saturate cola=%0d change=%0d exp 255 255", ifc.cola_cnt, ifc.change_cnt);
        end
        drive(7'b0100001, 1'b0);
        checks++;
        if (ifc.cola_cnt !== 8'd255 || ifc.change_cnt !== 8'd255 || ifc.po_cola !== 1'b1) begin
            failures++;
            $display("FAIL saturate_hold cola=%0d change=%0d po=%b exp 255 255 1", ifc.cola_cnt, ifc.change_cnt, ifc.po_cola);
        end
    endtask

    task automatic test_reset_mid_dispense();
        int highs;
        highs = 0;
        apply_reset();
        drive(7'b0010000, 1'b0);
        drive(7'b1000001, 1'b0);
        drive(7'b1000001, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 24'h0) begin
            failures++;
            $display("FAIL reset_mid dut=%h exp=%h", dut_vec(), 24'h0);
        end
        @(negedge sys_clk);
        ifc.state = 7'b0000001;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(7'b0000001, 1'b0);
            if (ifc.po_cola === 1'b1 || ifc.po_money === 1'b1) highs++;
        end
        checks++;
        if (highs !== 0 || ifc.cola_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_release pulse_cycles=%0d cola=%0d exp 0 0", highs, ifc.cola_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] credits [5] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000};
        logic [6:0] s;
        logic       c;
        int         r;
        int         errs;
        errs = 0;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) s = credits[$urandom_range(0, 4)];
            else if (r < 90) s = ($urandom_range(0, 1) == 0) ? 7'b0100001 : 7'b1000001;
            else s = 7'($urandom_range(0, 127));
            if (($urandom_range(0, 19) < 17) && is_vend(m_prev)) s = m_prev;
            c = ($urandom_range(0, 7) == 0);
            drive(s, c);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                errs++;
                if (errs <= 10) $display("FAIL random_cyc[%0d] state=%b dut=%h exp=%h", i, s, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        ifc.state   = 7'b0000001;
        ifc.err_clr = 1'b0;
        model_reset();
        test_reset();
        test_credit_display();
        test_vend_cola();
        test_vend_change();
        test_back_to_back();
        test_illegal();
        test_saturation();
        test_reset_mid_dispense();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
